// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Bytes enter a FIFO through a valid/ready write port and are sent LSB-first
// at CLKS_PER_BIT clocks per bit. The line idles at mark (1).
// Optional feature macro: UART_TX_PARITY_EN. When defined, it adds an even parity bit (8E1).
// When undefined, frames are 8N1.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int FIFO_DEPTH   = 16,
   parameter int FIFO_AW      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         wr_data,
   input  logic               wr_valid,
   output logic               wr_ready,
   output logic               txd,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_count
);

   localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [FIFO_AW:0]  CNT_FULL  = (FIFO_AW+1)'(FIFO_DEPTH);
   localparam logic [FIFO_AW:0]  CNT_ONE   = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW:0]   r_count;
   logic [FIFO_AW:0]   w_count_next;
   logic               r_wr_ready;

   state_t             r_state;
   logic [BAUD_W-1:0]  r_baud;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_txd;
   logic               r_busy;
`ifdef UART_TX_PARITY_EN
   logic               r_parity;
`endif

   logic               w_push;
   logic               w_pop;
   logic               w_bit_end;
   logic               w_frame_slot;
   logic               w_next_idle;
   logic [7:0]         w_head;

   // A pop can only happen when the line is free (IDLE) or a STOP period ends;
   // both rely on the registered count, so a fresh byte is never popped on
   // the edge that writes it.
   assign w_push       = wr_valid && r_wr_ready;
   assign w_bit_end    = (r_baud == BAUD_LAST);
   assign w_frame_slot = (r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end);
   assign w_pop        = w_frame_slot && (r_count != '0);
   assign w_next_idle  = w_frame_slot && !w_pop;
   assign w_head       = r_mem[r_rd_ptr];

   // Occupancy after this edge; push and pop together leave it unchanged
   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop)
         w_count_next = r_count + CNT_ONE;
      else if (!w_push && w_pop)
         w_count_next = r_count - CNT_ONE;
   end

   // FIFO storage; the read is captured by the shift register on pop
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= wr_data;
   end

   // FIFO pointers, occupancy and write-side handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_wr_ready <= 1'b1;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         r_count    <= w_count_next;
         r_wr_ready <= (w_count_next < CNT_FULL);
      end
   end

   // Transmit FSM with registered line output and busy flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_txd     <= 1'b1;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_busy <= !w_next_idle || (w_count_next != '0);
         if (w_pop) begin
            // Shared by IDLE and end-of-STOP: load the next byte, start bit out
            r_shift   <= w_head;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^w_head;
`endif
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_txd     <= 1'b0;
            r_state   <= S_START;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_txd <= 1'b1;
               end
               S_START: begin
                  if (w_bit_end) begin
                     r_baud  <= '0;
                     r_txd   <= r_shift[0];
                     r_state <= S_DATA;
                  end else begin
                     r_baud <= r_baud + BAUD_ONE;
                  end
               end
               S_DATA: begin
                  if (w_bit_end) begin
                     r_baud <= '0;
                     if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        r_txd   <= r_parity;
                        r_state <= S_PARITY;
`else
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
`endif
                     end else begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_txd     <= r_shift[1];
                     end
                  end else begin
                     r_baud <= r_baud + BAUD_ONE;
                  end
               end
`ifdef UART_TX_PARITY_EN
               S_PARITY: begin
                  if (w_bit_end) begin
                     r_baud  <= '0;
                     r_txd   <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_baud <= r_baud + BAUD_ONE;
                  end
               end
`endif
               S_STOP: begin
                  if (w_bit_end) begin
                     r_baud  <= '0;
                     r_txd   <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_baud <= r_baud + BAUD_ONE;
                  end
               end
               default: begin
                  r_txd   <= 1'b1;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign wr_ready   = r_wr_ready;
   assign txd        = r_txd;
   assign busy       = r_busy;
   assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (CLKS_PER_BIT = 4, FIFO_DEPTH = 16).
// The reference model keeps a byte queue and the current frame as a bit vector.
// The expected line level is frame_bit[position / CLKS_PER_BIT].
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    wr_data;
   logic          wr_valid;
   logic          wr_ready;
   logic          txd;
   logic          busy;
   logic [AW:0]   fifo_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   logic [7:0] m_q[$];
   bit         m_active = 1'b0;
   int         m_pos    = 0;
   bit [10:0]  m_bits   = '1;
   bit         m_push   = 1'b0;

   uart_tx_fifo #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH),
      .FIFO_AW     (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .txd       (txd),
      .busy      (busy),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   function automatic void start_frame(logic [7:0] d);
      m_bits    = '1;
      m_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++)
         m_bits[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
      m_bits[9] = ^d;
`endif
      m_active = 1'b1;
      m_pos    = 0;
   endfunction

   // One clock edge of the reference model, using the inputs seen at that edge
   task automatic model_edge();
      m_push = 1'b0;
      if (rst) begin
         m_q.delete();
         m_active = 1'b0;
         m_pos    = 0;
      end else begin
         m_push = wr_valid && (m_q.size() < DEPTH);
         if (m_active) begin
            m_pos++;
            if (m_pos == NBITS * CPB)
               m_active = 1'b0;
         end
         if (!m_active && m_q.size() > 0)
            start_frame(m_q.pop_front());
         if (m_push)
            m_q.push_back(wr_data);
      end
   endtask

   task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      logic exp_txd;
      exp_txd = m_active ? m_bits[m_pos / CPB] : 1'b1;
      check_val("txd", {31'b0, txd}, {31'b0, exp_txd});
      check_val("fifo_count", {27'b0, fifo_count}, m_q.size());
      check_val("wr_ready", {31'b0, wr_ready}, {31'b0, (m_q.size() < DEPTH)});
      check_val("busy", {31'b0, busy}, {31'b0, (m_active || m_q.size() != 0)});
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_all();
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++)
         step();
   endtask

   task automatic drain(int budget);
      int n;
      n = 0;
      while ((m_active || m_q.size() > 0) && n < budget) begin
         step();
         n++;
      end
      check_val("drain_timeout", {31'b0, (m_active || m_q.size() > 0)}, 32'd0);
      run(3);
   endtask

   task automatic write_one(logic [7:0] d);
      wr_data  = d;
      wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
   endtask

   initial begin
      int  n_acc;
      int  guard;
      bit  saw_full;

      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_data  = 8'h00;

      // reset
      run(2);
      check_val("rst_txd", {31'b0, txd}, 32'd1);
      check_val("rst_ready", {31'b0, wr_ready}, 32'd1);
      check_val("rst_busy", {31'b0, busy}, 32'd0);
      check_val("rst_count", {27'b0, fifo_count}, 32'd0);
      rst = 1'b0;
      run(3);

      // single byte 0x55 while idle: latency and full frame
      write_one(8'h55);
      check_val("lat_count1", {27'b0, fifo_count}, 32'd1);
      check_val("lat_txd_hi", {31'b0, txd}, 32'd1);
      step();
      check_val("lat_txd_lo", {31'b0, txd}, 32'd0);
      check_val("lat_count0", {27'b0, fifo_count}, 32'd0);
      drain(200);
      check_val("idle_busy", {31'b0, busy}, 32'd0);

      // two bytes on consecutive cycles: back-to-back frames
      wr_valid = 1'b1;
      wr_data  = 8'hA3;
      step();
      wr_data  = 8'h0F;
      step();
      wr_valid = 1'b0;
      drain(300);

      // 20 writes held: FIFO fills, later bytes wait for pops
      n_acc    = 0;
      guard    = 0;
      saw_full = 1'b0;
      wr_valid = 1'b1;
      wr_data  = 8'($urandom_range(0, 255));
      while (n_acc < 20 && guard < 3000) begin
         step();
         guard++;
         if (m_push) begin
            n_acc++;
            wr_data = 8'($urandom_range(0, 255));
         end
         if (fifo_count === 5'd16 && wr_ready === 1'b0)
            saw_full = 1'b1;
      end
      wr_valid = 1'b0;
      check_val("fill_accepts", n_acc, 32'd20);
      check_val("full_seen", {31'b0, saw_full}, 32'd1);
      drain(2000);

      // reset at the 5th data bit of 0x3C with 3 bytes queued
      write_one(8'h3C);
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = 8'($urandom_range(0, 255));
         step();
      end
      wr_valid = 1'b0;
      guard = 0;
      while (!(m_active && m_pos == 5 * CPB + 1) && guard < 200) begin
         step();
         guard++;
      end
      check_val("mid_reach", {31'b0, (m_active && m_pos == 5 * CPB + 1)}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("mid_txd", {31'b0, txd}, 32'd1);
      check_val("mid_count", {27'b0, fifo_count}, 32'd0);
      check_val("mid_busy", {31'b0, busy}, 32'd0);
      run(60);
      check_val("mid_quiet", {31'b0, txd}, 32'd1);

      // reset during a write cycle
      rst      = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h99;
      step();
      rst      = 1'b0;
      wr_valid = 1'b0;
      step();
      check_val("rstwr_count", {27'b0, fifo_count}, 32'd0);
      run(5);

      // parity-sensitive bytes (0x07 odd weight, 0x03 even weight)
      write_one(8'h07);
      write_one(8'h03);
      drain(300);

      // random traffic: sparse, then dense enough to keep the FIFO full
      for (int i = 0; i < 1500; i++) begin
         wr_valid = ($urandom_range(0, 39) == 0);
         wr_data  = 8'($urandom_range(0, 255));
         step();
      end
      for (int i = 0; i < 1500; i++) begin
         wr_valid = ($urandom_range(0, 9) < 3);
         wr_data  = 8'($urandom_range(0, 255));
         step();
      end
      wr_valid = 1'b0;
      drain(2000);
      check_val("end_busy", {31'b0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
